display_7_seg_mux: RTL and testbench

- Parametrised multi-digit, time-multiplexed 7-segment scan driver. Successor to the fixed 4-digit scanner.
- Generalised in digit count, refresh period and inter-digit dead time.
- Adds per-digit decimal points, per-digit blink, an enable, and an integrated registered hex decoder.
- Sits between the result/BCD formatting logic and the board's common-anode display pins.

---
 rtl/display_7_seg_mux.sv | 205 ++++++++++++++++++++
 tb/tb_display_7_seg_mux.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/display_7_seg_mux.sv
// Time-multiplexed common-anode 7-segment scan driver with blink, per-digit dp and hex decode.
// Optional leading-zero blanking is enabled by defining DISPLAY_7_SEG_MUX_LZB_EN.
module display_7_seg_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 25000000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    scan_wrap
);
   localparam int POS_W   = $clog2(NUM_DIGITS);
   localparam int PRE_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int PRE_W   = $clog2(PRE_MAX);
   localparam int BLINK_W = $clog2(BLINK_DIV);

   localparam logic [PRE_W-1:0]   SHOW_LAST  = PRE_W'(REFRESH_DIV - 1);
   localparam logic [PRE_W-1:0]   BLANK_LAST = PRE_W'(BLANK_CYCLES - 1);
   localparam logic [POS_W-1:0]   POSN_LAST  = POS_W'(NUM_DIGITS - 1);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

   state_t                state_q, state_d;
   logic [POS_W-1:0]      posn_q, posn_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic                  wrap_q, wrap_d;
   logic                  hide_q, hide_d;

   logic [POS_W-1:0]      next_posn;
   logic [POS_W-1:0]      entry_posn;
   logic                  entry_hide;
   logic                  load;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'h0: decode = 7'b1000000;
         4'h1: decode = 7'b1111001;
         4'h2: decode = 7'b0100100;
         4'h3: decode = 7'b0110000;
         4'h4: decode = 7'b0011001;
         4'h5: decode = 7'b0010010;
         4'h6: decode = 7'b0000010;
         4'h7: decode = 7'b1111000;
         4'h8: decode = 7'b0000000;
         4'h9: decode = 7'b0010000;
         4'hA: decode = 7'b0001000;
         4'hB: decode = 7'b0000011;
         4'hC: decode = 7'b1000110;
         4'hD: decode = 7'b0100001;
         4'hE: decode = 7'b0000110;
         default: decode = 7'b0001110;
      endcase
   endfunction

   // Lit anode for a digit, dropped while hidden or in the off half of its blink.
   function automatic logic [NUM_DIGITS-1:0] lit_anode(input logic [POS_W-1:0] p,
                                                       input logic hide,
                                                       input logic phase,
                                                       input logic [NUM_DIGITS-1:0] mask);
      logic [NUM_DIGITS-1:0] a;
      a = '1;
      if (!hide && !(phase && mask[p]))
         a[p] = 1'b0;
      return a;
   endfunction

   assign next_posn  = (posn_q == POSN_LAST) ? '0 : posn_q + 1'b1;
   // Without a BLANK gap, a digit is entered on the same edge the previous one exits.
   assign entry_posn = (state_q == SHOW) ? next_posn : posn_q;

`ifdef DISPLAY_7_SEG_MUX_LZB_EN
   logic [NUM_DIGITS-1:0] nz;
   logic [NUM_DIGITS-1:0] upper_nz;
   genvar gi;
   for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
      assign nz[gi]       = |digits_in[4*gi +: 4];
      assign upper_nz[gi] = |nz[NUM_DIGITS-1:gi];
   end
   assign entry_hide = (entry_posn != '0) && !upper_nz[entry_posn];
`else
   assign entry_hide = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      posn_d        = posn_q;
      pre_d         = pre_q;
      seg_d         = seg_q;
      dp_d          = dp_q;
      an_d          = '1;
      wrap_d        = 1'b0;
      hide_d        = hide_q;
      load          = 1'b0;
      blink_cnt_d   = blink_cnt_q + 1'b1;
      blink_phase_d = blink_phase_q;

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end

      if (!en) begin
         state_d = IDLE;
         posn_d  = '0;
         pre_d   = '0;
         seg_d   = 7'h7F;
         dp_d    = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               pre_d = '0;
               seg_d = 7'h7F;
               dp_d  = 1'b1;
               if (BLANK_CYCLES == 0) begin
                  state_d = SHOW;
                  load    = 1'b1;
               end else begin
                  state_d = BLANK;
               end
            end
            BLANK: begin
               if (pre_q == BLANK_LAST) begin
                  state_d = SHOW;
                  pre_d   = '0;
                  load    = 1'b1;
               end else begin
                  pre_d = pre_q + 1'b1;
               end
            end
            SHOW: begin
               if (pre_q == SHOW_LAST) begin
                  pre_d  = '0;
                  posn_d = next_posn;
                  wrap_d = (posn_q == POSN_LAST);
                  if (BLANK_CYCLES == 0)
                     load = 1'b1;
                  else
                     state_d = BLANK;
               end else begin
                  pre_d = pre_q + 1'b1;
                  an_d  = lit_anode(posn_q, hide_q, blink_phase_q, blink_mask);
               end
            end
            default: begin
               state_d = IDLE;
               posn_d  = '0;
               pre_d   = '0;
            end
         endcase
      end

      if (load) begin
         seg_d  = decode(digits_in[4*entry_posn +: 4]);
         dp_d   = ~dp_in[entry_posn] | entry_hide;
         hide_d = entry_hide;
         an_d   = lit_anode(entry_posn, entry_hide, blink_phase_q, blink_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         posn_q        <= '0;
         pre_q         <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         seg_q         <= 7'h7F;
         dp_q          <= 1'b1;
         an_q          <= '1;
         wrap_q        <= 1'b0;
         hide_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         posn_q        <= posn_d;
         pre_q         <= pre_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         an_q          <= an_d;
         wrap_q        <= wrap_d;
         hide_q        <= hide_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_q;
   assign an        = an_q;
   assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_display_7_seg_mux.sv
// Randomised bench for display_7_seg_mux, checked against a frame-timeline model of the scan.
// Honours DISPLAY_7_SEG_MUX_LZB_EN in its model when the RTL is built with it.
module tb_display_7_seg_mux;
   localparam int ND     = 4;
   localparam int RD     = 8;
   localparam int BC     = 2;
   localparam int BD     = 64;
   localparam int PERIOD = RD + BC;
   localparam int FRAME  = ND * PERIOD;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b1;
   logic        en         = 1'b0;
   logic [15:0] digits_in  = '0;
   logic [3:0]  dp_in      = '0;
   logic [3:0]  blink_mask = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        scan_wrap;

   display_7_seg_mux #(
      .NUM_DIGITS  (ND),
      .REFRESH_DIV (RD),
      .BLANK_CYCLES(BC),
      .BLINK_DIV   (BD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .digits_in (digits_in),
      .dp_in     (dp_in),
      .blink_mask(blink_mask),
      .seg       (seg),
      .dp        (dp),
      .an        (an),
      .scan_wrap (scan_wrap)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [6:0] seg_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   // Model: s counts edges since the enable was first seen (-1 while idle).
   int         n_edges;
   int         s;
   logic [3:0] exp_an;
   logic [6:0] exp_seg;
   logic       exp_dp;
   logic       exp_wrap;
   logic       exp_hide;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", tag, got, want, $time);
      end
   endtask

   function automatic logic lzb_hidden(input int d);
`ifdef DISPLAY_7_SEG_MUX_LZB_EN
      int msd;
      msd = 0;
      for (int i = 0; i < ND; i++)
         if (digits_in[4*i +: 4] != 4'h0) msd = i;
      return d > msd;
`else
      return (d < 0);
`endif
   endfunction

   task automatic model_reset();
      n_edges  = 0;
      s        = -1;
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      exp_dp   = 1'b1;
      exp_wrap = 1'b0;
      exp_hide = 1'b0;
   endtask

   task automatic model_edge();
      int   m;
      int   d;
      logic phase;
      phase = ((n_edges / BD) % 2) == 1;
      n_edges++;
      exp_wrap = 1'b0;
      exp_an   = 4'hF;
      if (!en) begin
         s       = -1;
         exp_seg = 7'h7F;
         exp_dp  = 1'b1;
      end else if (s < 0) begin
         s = 0;
      end else begin
         s++;
         m = s % PERIOD;
         d = (s / PERIOD) % ND;
         exp_wrap = (s % FRAME) == 0;
         if (m >= BC) begin
            if (m == BC) begin
               exp_seg  = seg_tab[digits_in[4*d +: 4]];
               exp_hide = lzb_hidden(d);
               exp_dp   = ~dp_in[d] | exp_hide;
            end
            if (!exp_hide && !(phase && blink_mask[d]))
               exp_an[d] = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      check_val("an", 32'(an), 32'(exp_an));
      check_val("seg", 32'(seg), 32'(exp_seg));
      check_val("dp", 32'(dp), 32'(exp_dp));
      check_val("scan_wrap", 32'(scan_wrap), 32'(exp_wrap));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // Called 1 time unit after an edge: reset lands between edges and must act at once.
   task automatic async_reset();
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int found;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_outputs();
      repeat (3) begin
         @(posedge clk);
         #1 check_outputs();
      end
      #2 rst_n = 1'b1;
      $display("reset: held 3 cycles, released");

      repeat (20) step();
      $display("idle: en=0 for 20 cycles");

      en        = 1'b1;
      digits_in = 16'h1234;
      dp_in     = 4'b0100;
      repeat (45) step();
      digits_in = 16'hFFFF;
      repeat (20) step();
      $display("scan: 16'h1234 then 16'hFFFF mid-SHOW");

      blink_mask = 4'b0010;
      for (int i = 0; i < 256; i++) begin
         step();
         if ($urandom_range(7, 0) == 0) digits_in = 16'($urandom);
      end
      blink_mask = 4'b0000;
      $display("blink: mask 0010 for 256 cycles");

      found = 0;
      for (int i = 0; i < 60 && found == 0; i++) begin
         step();
         if (s >= 0 && (s % PERIOD) >= BC && ((s / PERIOD) % ND) == 2) found = 1;
      end
      check_val("reach_digit2", 32'(found), 32'd1);
      en = 1'b0;
      step();
      check_val("disable_an", 32'(an), 32'hF);
      en = 1'b1;
      repeat (2) step();
      check_val("reen_dark", 32'(an), 32'hF);
      step();
      check_val("reen_lit", 32'(an), 32'b1110);
      $display("disable/re-enable during digit 2");

      repeat (12) step();
      if (s >= 0 && (s % PERIOD) < BC) async_reset();
      for (int i = 0; i < 500; i++) begin
         step();
         if ($urandom_range(3, 0) == 0) digits_in = 16'($urandom);
         if ($urandom_range(7, 0) == 0) dp_in = 4'($urandom);
         if ($urandom_range(31, 0) == 0) blink_mask = 4'($urandom);
         if (!en) en = 1'b1;
         else if ($urandom_range(49, 0) == 0) en = 1'b0;
         if (rst_n && s >= 0 && (s % PERIOD) < BC && $urandom_range(39, 0) == 0) async_reset();
      end
      $display("random: 500 cycles of mixed stimulus");

      en         = 1'b1;
      dp_in      = 4'hF;
      blink_mask = 4'h0;
      digits_in  = 16'h0050;
      repeat (45) step();
      digits_in  = 16'h0000;
      repeat (45) step();
      $display("words 16'h0050 and 16'h0000");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
